// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 burst master.
// Holds the FSM state enum, AXI burst/response encodings and the 4 KB boundary.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BOUNDARY_4K = 4096;
  // Beat count of one burst: up to 256, so 9 bits.
  localparam int BEATS_W = 9;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: the largest burst that fits the remaining beats,
// the burst length limit, and the distance to the next 4 KB boundary.
module axi_burst_calc
  import axi_burst_pkg::*;
#(
  parameter int LEN_WIDTH     = 12,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [LEN_WIDTH:0]   remaining,
  input  logic [11:0]          addr,
  output logic [BEATS_W-1:0]   beats,
  output logic [7:0]           len
);

  localparam int SIZE = $clog2(STRB_WIDTH);

  logic [31:0] to_4k;
  logic [31:0] pick;

  always_comb begin
    to_4k = (32'(BOUNDARY_4K) - 32'(addr)) >> SIZE;
    pick  = 32'(remaining);
    if (pick > 32'(MAX_BURST_LEN)) pick = 32'(MAX_BURST_LEN);
    if (pick > to_4k) pick = to_4k;
    beats = BEATS_W'(pick);
    len   = 8'(pick - 32'd1);
  end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master: splits a command into 4 KB-safe INCR bursts, streams write data
// out / read data back, and reports one done/err per command.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 12,
  parameter int MAX_BURST_LEN = 256,
  parameter int AXI_ID        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next, addr_step;
  logic [LEN_WIDTH:0]    remaining_reg, remaining_next, remaining_after;
  logic [BEATS_W-1:0]    beats_reg, calc_beats;
  logic [7:0]            beat_cnt_reg, beat_cnt_next, calc_len, burst_len;
  logic                  err_reg, err_next, done_reg, done_next;
  logic                  load_burst, final_burst;
  logic                  unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Sized from the next-state address/remaining so the burst is ready the cycle AW/AR rises.
  axi_burst_calc #(
    .LEN_WIDTH    (LEN_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_calc (
    .remaining(remaining_next),
    .addr     (addr_next[11:0]),
    .beats    (calc_beats),
    .len      (calc_len)
  );

  assign final_burst     = (remaining_reg == (LEN_WIDTH+1)'(beats_reg));
  assign addr_step       = addr_reg + (ADDR_WIDTH'(beats_reg) << SIZE);
  assign remaining_after = remaining_reg - (LEN_WIDTH+1)'(beats_reg);
  assign burst_len       = 8'(beats_reg - BEATS_W'(1));

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    beat_cnt_next  = beat_cnt_reg;
    err_next       = err_reg;
    done_next      = 1'b0;
    load_burst     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_next      = cmd_addr & ALIGN_MASK;
          remaining_next = {1'b0, cmd_len} + (LEN_WIDTH+1)'(1);
          err_next       = 1'b0;
          load_burst     = 1'b1;
          state_next     = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: if (m_axi_awready) state_next = ST_WR_DATA;
      ST_WR_DATA: begin
        if (wr_valid && m_axi_wready) begin
          beat_cnt_next = beat_cnt_reg - 8'd1;
          if (beat_cnt_reg == '0) state_next = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          err_next       = err_reg | (m_axi_bresp != RESP_OKAY);
          addr_next      = addr_step;
          remaining_next = remaining_after;
          if (remaining_after == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_WR_ADDR;
            load_burst = 1'b1;
          end
        end
      end
      ST_RD_ADDR: if (m_axi_arready) state_next = ST_RD_DATA;
      ST_RD_DATA: begin
        if (m_axi_rvalid && rd_ready) begin
          // A slave whose rlast disagrees with our beat count is flagged, but rlast still wins.
          err_next      = err_reg | (m_axi_rresp != RESP_OKAY) | (m_axi_rlast != (beat_cnt_reg == '0));
          beat_cnt_next = beat_cnt_reg - 8'd1;
          if (m_axi_rlast) begin
            if (final_burst) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              addr_next      = addr_step;
              remaining_next = remaining_after;
              state_next     = ST_RD_ADDR;
              load_burst     = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      beats_reg     <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      err_reg       <= err_next;
      done_reg      <= done_next;
      if (load_burst) begin
        beats_reg    <= calc_beats;
        beat_cnt_reg <= calc_len;
      end else begin
        beat_cnt_reg <= beat_cnt_next;
      end
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = burst_len;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_reg == ST_WR_ADDR);

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = wr_strb;
  assign m_axi_wlast  = (state_reg == ST_WR_DATA) && (beat_cnt_reg == '0);
  assign m_axi_wvalid = (state_reg == ST_WR_DATA) && wr_valid;
  assign wr_ready     = (state_reg == ST_WR_DATA) && m_axi_wready;
  assign m_axi_bready = (state_reg == ST_WR_RESP);

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = burst_len;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_reg == ST_RD_ADDR);

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = (state_reg == ST_RD_DATA) && m_axi_rvalid;
  assign m_axi_rready = (state_reg == ST_RD_DATA) && rd_ready;
  assign rd_last      = rd_valid && m_axi_rlast && final_burst;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a command table run against a randomly throttled
// AXI slave model, with scoreboards for bursts, write beats and read beats.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = '0;
  logic [11:0] cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '1;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready = 0, done, err;
  logic [7:0]  m_axi_awid, m_axi_arid, m_axi_awlen, m_axi_arlen;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_arvalid;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic        m_axi_awready = 0, m_axi_arready = 0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 0;
  logic [7:0]  m_axi_bid = '0, m_axi_rid = '0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic        m_axi_bvalid = 0, m_axi_bready;
  logic [31:0] m_axi_rdata = '0;
  logic        m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [11:0] len;
    bit          bp;
    int          err_burst;
    int          nb;
    logic [15:0] a0;
    logic [7:0]  l0;
    logic [15:0] a1;
    logic [7:0]  l1;
    bit          exp_err;
  } vec_t;

  typedef struct packed { logic [15:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic [31:0] data; logic last; } rbeat_t;

  vec_t        vecs[8];
  burst_t      aw_exp[$], ar_exp[$];
  rbeat_t      rexp[$];
  logic [31:0] wq[$], wexp[$];
  logic [31:0] mem[0:16383];
  logic [31:0] ref_mem[0:16383];

  int checks = 0, errors = 0;
  bit s_wact = 0, s_bpend = 0, s_ract = 0;
  logic [15:0] s_waddr = '0, s_raddr = '0;
  logic [1:0]  s_bresp = '0;
  int s_wlen = 0, s_wbeat = 0, s_rlen = 0, s_rbeat = 0, s_bidx = 0;
  int err_burst = 0, done_cnt = 0, w_hs = 0;
  bit exp_err = 0, rd_bp = 0, w_stall = 0, cmd_pend = 0, lat_chk = 0;

  function automatic logic [13:0] widx(logic [15:0] a, int b);
    return 14'(32'(a[15:2]) + b);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive everything at negedge, then resolve the handshakes the next posedge will see.
  task automatic step();
    burst_t b;
    rbeat_t r;
    logic [31:0] ed;
    logic [13:0] wi;
    @(negedge clk);
    m_axi_awready = !s_wact && !s_bpend && ($urandom_range(0, 3) != 0);
    m_axi_wready  = s_wact && ($urandom_range(0, 3) != 0);
    m_axi_bvalid  = s_bpend;
    m_axi_bresp   = s_bresp;
    m_axi_arready = !s_ract && ($urandom_range(0, 3) != 0);
    m_axi_rvalid  = s_ract && ($urandom_range(0, 3) != 0);
    m_axi_rdata   = s_ract ? mem[widx(s_raddr, s_rbeat)] : '0;
    m_axi_rlast   = s_ract && (s_rbeat == s_rlen);
    m_axi_rresp   = RESP_OKAY;
    wr_valid      = (wq.size() > 0) && !w_stall && ($urandom_range(0, 3) != 0);
    wr_data       = (wq.size() > 0) ? wq[0] : '0;
    wr_strb       = '1;
    rd_ready      = rd_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    cmd_valid     = cmd_pend;
    #1;
    if (lat_chk) begin
      chk("addr_valid_latency", m_axi_awvalid | m_axi_arvalid, 1);
      lat_chk = 0;
    end
    if (done) begin
      done_cnt++;
      chk("done_err", err, exp_err);
      chk("done_cmd_ready", cmd_ready, 1);
    end
    if (m_axi_bvalid && m_axi_bready) s_bpend = 0;
    if (m_axi_wvalid) chk("w_after_aw", s_wact, 1);
    if (m_axi_wvalid && m_axi_wready) begin
      chk("w_expected", wexp.size() > 0, 1);
      ed = (wexp.size() > 0) ? wexp.pop_front() : '0;
      chk("wdata", m_axi_wdata, ed);
      chk("wlast", m_axi_wlast, s_wbeat == s_wlen);
      wi = widx(s_waddr, s_wbeat);
      for (int k = 0; k < 4; k++)
        if (m_axi_wstrb[k]) mem[wi][k*8 +: 8] = m_axi_wdata[k*8 +: 8];
      s_wbeat++;
      w_hs++;
      if (s_wbeat > s_wlen) begin
        s_wact  = 0;
        s_bpend = 1;
        s_bidx++;
        s_bresp = (s_bidx == err_burst) ? RESP_SLVERR : RESP_OKAY;
      end
    end
    if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
    if (m_axi_awvalid && m_axi_awready) begin
      chk("aw_expected", aw_exp.size() > 0, 1);
      b = (aw_exp.size() > 0) ? aw_exp.pop_front() : '0;
      chk("awaddr", m_axi_awaddr, b.addr);
      chk("awlen", m_axi_awlen, b.len);
      chk("awsize", m_axi_awsize, 3'd2);
      chk("awburst", m_axi_awburst, 2'b01);
      s_wact = 1; s_waddr = m_axi_awaddr; s_wlen = int'(m_axi_awlen); s_wbeat = 0;
    end
    if (m_axi_rvalid && m_axi_rready) begin
      s_rbeat++;
      if (s_rbeat > s_rlen) s_ract = 0;
    end
    if (rd_valid && rd_ready) begin
      chk("r_expected", rexp.size() > 0, 1);
      r = (rexp.size() > 0) ? rexp.pop_front() : '0;
      chk("rd_data", rd_data, r.data);
      chk("rd_last", rd_last, r.last);
    end
    if (m_axi_arvalid && m_axi_arready) begin
      chk("ar_expected", ar_exp.size() > 0, 1);
      b = (ar_exp.size() > 0) ? ar_exp.pop_front() : '0;
      chk("araddr", m_axi_araddr, b.addr);
      chk("arlen", m_axi_arlen, b.len);
      chk("arsize", m_axi_arsize, 3'd2);
      chk("arburst", m_axi_arburst, 2'b01);
      s_ract = 1; s_raddr = m_axi_araddr; s_rlen = int'(m_axi_arlen); s_rbeat = 0;
    end
    if (cmd_valid && cmd_ready) begin
      cmd_pend = 0;
      lat_chk  = 1;
    end
  endtask

  task automatic run_cmd(input vec_t v, input int id);
    logic [31:0] d;
    int n;
    for (int i = 0; i < v.nb; i++) begin
      if (v.wr) aw_exp.push_back({(i == 0) ? v.a0 : v.a1, (i == 0) ? v.l0 : v.l1});
      else      ar_exp.push_back({(i == 0) ? v.a0 : v.a1, (i == 0) ? v.l0 : v.l1});
    end
    for (int k = 0; k <= int'(v.len); k++) begin
      if (v.wr) begin
        d = (v.addr == 16'h0100) ? 32'h11111111 * (k + 1) : $urandom;
        wq.push_back(d);
        wexp.push_back(d);
        ref_mem[widx(v.addr, k)] = d;
      end else begin
        rexp.push_back({ref_mem[widx(v.addr, k)], k == int'(v.len)});
      end
    end
    err_burst = v.err_burst; exp_err = v.exp_err; rd_bp = v.bp;
    s_bidx = 0; done_cnt = 0;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_pend = 1;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      step();
      n++;
    end
    repeat (4) step();
    chk("done_count", done_cnt, 1);
    chk("queues_drained", aw_exp.size() + ar_exp.size() + rexp.size() + wq.size() + wexp.size(), 0);
    $display("cmd %0d: %s addr=%h len=%0d bursts=%0d cycles=%0d err=%0b",
             id, v.wr ? "write" : "read ", v.addr, v.len, v.nb, n, err);
  endtask

  initial begin
    int n;
    vec_t post_w, post_r;
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 32'hA5A50000 + i;
      ref_mem[i] = 32'hA5A50000 + i;
    end
    //           wr addr      len   bp eb nb a0        l0    a1        l1    err
    vecs[0] = '{1, 16'h0100, 12'd3,   0, 0, 1, 16'h0100, 8'd3,   16'h0000, 8'd0,  0};
    vecs[1] = '{0, 16'h0100, 12'd3,   0, 0, 1, 16'h0100, 8'd3,   16'h0000, 8'd0,  0};
    vecs[2] = '{1, 16'h0FF8, 12'd3,   0, 0, 2, 16'h0FF8, 8'd1,   16'h1000, 8'd1,  0};
    vecs[3] = '{1, 16'h2000, 12'd299, 0, 0, 2, 16'h2000, 8'd255, 16'h2400, 8'd43, 0};
    vecs[4] = '{0, 16'h2000, 12'd299, 1, 0, 2, 16'h2000, 8'd255, 16'h2400, 8'd43, 0};
    vecs[5] = '{1, 16'h0103, 12'd0,   0, 0, 1, 16'h0100, 8'd0,   16'h0000, 8'd0,  0};
    vecs[6] = '{1, 16'h3FF8, 12'd3,   0, 2, 2, 16'h3FF8, 8'd1,   16'h4000, 8'd1,  1};
    vecs[7] = '{0, 16'h0FF8, 12'd3,   0, 0, 2, 16'h0FF8, 8'd1,   16'h1000, 8'd1,  0};

    rst = 1;
    repeat (3) step();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rd_valid}, 0);
    chk("aw_consts", {m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot}, {8'd0, 1'b0, 4'b0011, 3'b000});
    chk("ar_consts", {m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot}, {8'd0, 1'b0, 4'b0011, 3'b000});
    rst = 0;
    step();

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], i);

    // Reset in the middle of a write burst, after two of four beats.
    cmd_write = 1; cmd_addr = 16'h0500; cmd_len = 12'd3;
    for (int k = 0; k < 4; k++) begin
      wq.push_back(32'hC0DE0000 + k);
      wexp.push_back(32'hC0DE0000 + k);
    end
    aw_exp.push_back({16'h0500, 8'd3});
    err_burst = 0; exp_err = 0; rd_bp = 0; w_hs = 0; done_cnt = 0; cmd_pend = 1;
    n = 0;
    while (w_hs < 2 && n < 1000) begin
      step();
      n++;
    end
    chk("rst_two_beats", w_hs, 2);
    w_stall = 1;
    rst = 1;
    step();
    s_wact = 0; s_bpend = 0; s_ract = 0;
    aw_exp.delete(); ar_exp.delete(); rexp.delete(); wq.delete(); wexp.delete();
    step();
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready_rd_valid", {m_axi_rready, rd_valid}, 0);
    chk("rst_done", done, 0);
    rst = 0;
    w_stall = 0;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_no_done", done_cnt, 0);
    $display("cmd 8: write addr=0500 len=3 abandoned by reset after %0d beats", w_hs);

    post_w = '{1, 16'h0600, 12'd1, 0, 0, 1, 16'h0600, 8'd1, 16'h0000, 8'd0, 0};
    post_r = '{0, 16'h0600, 12'd1, 1, 0, 1, 16'h0600, 8'd1, 16'h0000, 8'd0, 0};
    run_cmd(post_w, 9);
    run_cmd(post_r, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
